// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - core-side and APB-side signal bundle for apb_master_bridge
interface apb_master_bridge_if;
    // core data-bus side
    logic        transfer;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busErr;
    // APB3 side
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PENABLE;
    logic [3:0]  PSEL;
    logic [31:0] PRDATA0;
    logic [31:0] PRDATA1;
    logic [31:0] PRDATA2;
    logic [31:0] PRDATA3;
    logic        PREADY0;
    logic        PREADY1;
    logic        PREADY2;
    logic        PREADY3;

    // bridge view
    modport master (
        input  transfer, write, addr, wdata,
        input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        input  PREADY0, PREADY1, PREADY2, PREADY3,
        output rdata, ready, busErr,
        output PADDR, PWRITE, PWDATA, PENABLE, PSEL
    );

    // environment view: core plus the four peripherals
    modport slave (
        output transfer, write, addr, wdata,
        output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        output PREADY0, PREADY1, PREADY2, PREADY3,
        input  rdata, ready, busErr,
        input  PADDR, PWRITE, PWDATA, PENABLE, PSEL
    );
endinterface

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - core data bus to 4-slot APB3 bridge; optional ACCESS timeout under APB_TIMEOUT_EN
module apb_master_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
`ifdef APB_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    apb_master_bridge_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] paddr_q;
    logic        pwrite_q;
    logic [31:0] pwdata_q;
    logic [1:0]  slot_q;
    logic        mapped_q;

    logic        addr_mapped;
    logic        sel_ready;
    logic [31:0] sel_rdata;

    logic        ready_c;
    logic        bus_err_c;
    logic [31:0] rdata_c;

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  wait_cnt;
`endif

    assign addr_mapped = (bus.addr[31:14] == BASE_ADDR[31:14]);

    // Only the captured slot's PREADY/PRDATA are looked at; the others are don't-care.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = 32'd0;
        case (slot_q)
            2'd0: begin sel_ready = bus.PREADY0; sel_rdata = bus.PRDATA0; end
            2'd1: begin sel_ready = bus.PREADY1; sel_rdata = bus.PRDATA1; end
            2'd2: begin sel_ready = bus.PREADY2; sel_rdata = bus.PRDATA2; end
            default: begin sel_ready = bus.PREADY3; sel_rdata = bus.PRDATA3; end
        endcase
    end

    // State register; async reset drops PSEL/PENABLE immediately since both decode from state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture in IDLE; core-side changes after this are ignored until the next IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            paddr_q  <= 32'd0;
            pwrite_q <= 1'b0;
            pwdata_q <= 32'd0;
            slot_q   <= 2'd0;
            mapped_q <= 1'b0;
        end else if (state == IDLE && bus.transfer) begin
            paddr_q  <= bus.addr;
            pwrite_q <= bus.write;
            pwdata_q <= bus.wdata;
            slot_q   <= bus.addr[13:12];
            mapped_q <= addr_mapped;
        end
    end

`ifdef APB_TIMEOUT_EN
    // Wait-state counter: cleared while in SETUP, counts each stalled ACCESS cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 8'd0;
        end else if (state == SETUP) begin
            wait_cnt <= 8'd0;
        end else if (state == ACCESS && !sel_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`endif

    // Next state and the single-cycle completion outputs to the core.
    always_comb begin
        state_next = state;
        ready_c    = 1'b0;
        bus_err_c  = 1'b0;
        rdata_c    = 32'd0;
        case (state)
            IDLE: begin
                if (bus.transfer) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (!mapped_q) begin
                    ready_c    = 1'b1;
                    bus_err_c  = 1'b1;
                    state_next = IDLE;
                end else if (sel_ready) begin
                    ready_c    = 1'b1;
                    rdata_c    = sel_rdata;
                    state_next = IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else if (wait_cnt == TIMEOUT_LAST) begin
                    ready_c    = 1'b1;
                    bus_err_c  = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.PADDR   = paddr_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PENABLE = (state == ACCESS);
    assign bus.PSEL    = (state != IDLE && mapped_q) ? (4'b0001 << slot_q) : 4'b0000;
    assign bus.ready   = ready_c;
    assign bus.busErr  = bus_err_c;
    assign bus.rdata   = rdata_c;

endmodule
